// File: rtl/mask_range_acc.sv
// Streaming range-mask generator: expands [lo, hi] (with wrap) into a W-bit mask,
// applies it to an accumulator as LOAD/SET/CLR/FLUSH and queues one result per request.
module mask_range_acc #(
    parameter int W           = 32,
    parameter bit P_INCLUSIVE = 1'b1,
    localparam int X_W        = $clog2(W)
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           in_vld_i,
    output logic           in_rdy_o,
    input  logic [1:0]     in_op_i,
    input  logic [X_W-1:0] in_lo_i,
    input  logic [X_W-1:0] in_hi_i,
    output logic           out_vld_o,
    input  logic           out_rdy_i,
    output logic [W-1:0]   out_mask_o,
    output logic           out_err_o,
    output logic [W-1:0]   acc_o
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_FLUSH = 2'b11
    } op_e;

    op_e          op;
    logic [31:0]  lo_ext;
    logic [31:0]  hi_ext;
    logic         wrap;
    logic         oor;
    logic [W-1:0] range_mask;

    logic         push;
    logic         pop;
    logic         ent_err;
    logic [W-1:0] ent_mask;
    logic [W-1:0] r_eff;

    logic [W-1:0] acc_q,       acc_d;
    logic [1:0]   count_q,     count_d;
    logic [W-1:0] head_mask_q, head_mask_d;
    logic         head_err_q,  head_err_d;
    logic [W-1:0] tail_mask_q, tail_mask_d;
    logic         tail_err_q,  tail_err_d;

    assign op     = op_e'(in_op_i);
    assign lo_ext = 32'(in_lo_i);
    assign hi_ext = 32'(in_hi_i);
    assign wrap   = (lo_ext > hi_ext);

    // Indices can only exceed W-1 when W is not a power of two.
    generate
        if ((1 << X_W) != W) begin : g_oor
            assign oor = (lo_ext >= 32'(W)) || (hi_ext >= 32'(W));
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_comb begin
        range_mask = '0;
        for (int i = 0; i < W; i++) begin
            if (wrap) begin
                range_mask[i] = (32'(i) >= lo_ext) ||
                                (P_INCLUSIVE ? (32'(i) <= hi_ext) : (32'(i) < hi_ext));
            end else begin
                range_mask[i] = (32'(i) >= lo_ext) &&
                                (P_INCLUSIVE ? (32'(i) <= hi_ext) : (32'(i) < hi_ext));
            end
        end
    end

    assign in_rdy_o = (count_q != 2'd2);
    assign push     = in_vld_i && in_rdy_o;
    assign pop      = out_vld_o && out_rdy_i;

    // An erroring request applies an empty mask, so every op except FLUSH leaves acc alone.
    always_comb begin
        ent_err  = (op != OP_FLUSH) && oor;
        r_eff    = ent_err ? '0 : range_mask;
        acc_d    = acc_q;
        ent_mask = acc_q;
        case (op)
            OP_LOAD: begin
                ent_mask = ent_err ? acc_q : r_eff;
                if (push) acc_d = ent_mask;
            end
            OP_SET: begin
                ent_mask = acc_q | r_eff;
                if (push) acc_d = ent_mask;
            end
            OP_CLR: begin
                ent_mask = acc_q & ~r_eff;
                if (push) acc_d = ent_mask;
            end
            OP_FLUSH: begin
                ent_mask = acc_q;
                if (push) acc_d = '0;
            end
            default: begin
                ent_mask = acc_q;
            end
        endcase
    end

    always_comb begin
        count_d     = count_q;
        head_mask_d = head_mask_q;
        head_err_d  = head_err_q;
        tail_mask_d = tail_mask_q;
        tail_err_d  = tail_err_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_mask_d = ent_mask;
                    head_err_d  = ent_err;
                end else begin
                    tail_mask_d = ent_mask;
                    tail_err_d  = ent_err;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_mask_d = tail_mask_q;
                head_err_d  = tail_err_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                // push implies count < 2 and pop implies count > 0, so count is 1 here
                head_mask_d = ent_mask;
                head_err_d  = ent_err;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc_q       <= '0;
            count_q     <= 2'd0;
            head_mask_q <= '0;
            head_err_q  <= 1'b0;
            tail_mask_q <= '0;
            tail_err_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            head_mask_q <= head_mask_d;
            head_err_q  <= head_err_d;
            tail_mask_q <= tail_mask_d;
            tail_err_q  <= tail_err_d;
        end
    end

    assign out_vld_o  = (count_q != 2'd0);
    assign out_mask_o = head_mask_q;
    assign out_err_o  = head_err_q;
    assign acc_o      = acc_q;

endmodule

// File: tb/tb_mask_range_acc.sv
// Bench for mask_range_acc: three instances (W=8 inclusive, W=8 exclusive, W=6 inclusive)
// share one request stream and are compared against a queue-based reference model.
module tb_mask_range_acc;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst_n;
    logic       in_vld;
    logic [1:0] in_op;
    logic [2:0] in_lo, in_hi;
    logic       out_rdy;

    logic       r0, r1, r2, v0, v1, v2, e0, e1, e2;
    logic [7:0] m0, m1, a0, a1;
    logic [5:0] m2, a2;

    mask_range_acc #(.W(8), .P_INCLUSIVE(1'b1)) u_dut0 (
        .clk(clk), .arst_n(arst_n), .in_vld_i(in_vld), .in_rdy_o(r0), .in_op_i(in_op),
        .in_lo_i(in_lo), .in_hi_i(in_hi), .out_vld_o(v0), .out_rdy_i(out_rdy),
        .out_mask_o(m0), .out_err_o(e0), .acc_o(a0));
    mask_range_acc #(.W(8), .P_INCLUSIVE(1'b0)) u_dut1 (
        .clk(clk), .arst_n(arst_n), .in_vld_i(in_vld), .in_rdy_o(r1), .in_op_i(in_op),
        .in_lo_i(in_lo), .in_hi_i(in_hi), .out_vld_o(v1), .out_rdy_i(out_rdy),
        .out_mask_o(m1), .out_err_o(e1), .acc_o(a1));
    mask_range_acc #(.W(6), .P_INCLUSIVE(1'b1)) u_dut2 (
        .clk(clk), .arst_n(arst_n), .in_vld_i(in_vld), .in_rdy_o(r2), .in_op_i(in_op),
        .in_lo_i(in_lo), .in_hi_i(in_hi), .out_vld_o(v2), .out_rdy_i(out_rdy),
        .out_mask_o(m2), .out_err_o(e2), .acc_o(a2));

    localparam logic [1:0] LOAD = 2'b00, SET = 2'b01, CLR = 2'b10, FLUSH = 2'b11;

    typedef struct {
        logic [2:0][7:0] m;
        logic [2:0]      e;
    } ent_t;

    int         wd[3]  = '{8, 8, 6};
    int         inc[3] = '{1, 0, 1};
    logic [7:0] acc_m[3];
    ent_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Walk from lo towards hi modulo w; the length of the walk defines the range.
    function automatic logic [7:0] range_of(input int lo, input int hi, input int w, input int incl);
        logic [7:0] m = '0;
        int n = (hi - lo + w) % w;
        if (incl != 0) n++;
        for (int k = 0; k < n; k++) m[(lo + k) % w] = 1'b1;
        return m;
    endfunction

    task automatic check_all();
        logic [31:0] mo[3];
        logic [31:0] eo[3];
        logic [31:0] ao[3];
        logic [31:0] ro[3];
        logic [31:0] vo[3];
        mo = '{32'(m0), 32'(m1), 32'(m2)};
        eo = '{32'(e0), 32'(e1), 32'(e2)};
        ao = '{32'(a0), 32'(a1), 32'(a2)};
        ro = '{32'(r0), 32'(r1), 32'(r2)};
        vo = '{32'(v0), 32'(v1), 32'(v2)};
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rdy%0d", d), ro[d], 32'(q.size() != 2));
            check($sformatf("vld%0d", d), vo[d], 32'(q.size() != 0));
            check($sformatf("acc%0d", d), ao[d], 32'(acc_m[d]));
            if (q.size() != 0) begin
                check($sformatf("mask%0d", d), mo[d], 32'(q[0].m[d]));
                check($sformatf("err%0d", d), eo[d], 32'(q[0].e[d]));
            end
        end
    endtask

    task automatic cycle(input logic vld, input logic [1:0] op, input int lo, input int hi,
                         input logic ordy, output bit accepted);
        ent_t ent;
        ent_t tmp;
        bit   popped;
        in_vld  = vld;
        in_op   = op;
        in_lo   = lo[2:0];
        in_hi   = hi[2:0];
        out_rdy = ordy;
        @(posedge clk);
        accepted = vld && (q.size() != 2);
        popped   = (q.size() != 0) && ordy;
        if (popped) tmp = q.pop_front();
        if (accepted) begin
            for (int d = 0; d < 3; d++) begin
                logic       err;
                logic [7:0] r;
                err = (op != FLUSH) && (lo >= wd[d] || hi >= wd[d]);
                r   = err ? 8'h00 : range_of(lo, hi, wd[d], inc[d]);
                case (op)
                    LOAD:    begin if (!err) acc_m[d] = r; ent.m[d] = acc_m[d]; end
                    SET:     begin acc_m[d] = acc_m[d] | r;  ent.m[d] = acc_m[d]; end
                    CLR:     begin acc_m[d] = acc_m[d] & ~r; ent.m[d] = acc_m[d]; end
                    default: begin ent.m[d] = acc_m[d]; acc_m[d] = 8'h00; end
                endcase
                ent.e[d] = err;
            end
            q.push_back(ent);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic req(input logic [1:0] op, input int lo, input int hi);
        bit a;
        cycle(1'b1, op, lo, hi, 1'b1, a);
    endtask

    task automatic async_reset();
        in_vld = 1'b0;
        #1 arst_n = 1'b0;
        #1;
        check("rst_vld", 32'(v0), 32'd0);
        check("rst_acc", 32'(a0), 32'd0);
        check("rst_rdy", 32'(r0), 32'd1);
        check("rst_mask", 32'(m0), 32'd0);
        q.delete();
        for (int d = 0; d < 3; d++) acc_m[d] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        check_all();
    endtask

    initial begin
        bit         a;
        bit         pend;
        logic       vld;
        logic [1:0] op;
        int         lo, hi;
        arst_n = 1'b0; in_vld = 1'b0; in_op = 2'b00; in_lo = '0; in_hi = '0; out_rdy = 1'b0;
        for (int d = 0; d < 3; d++) acc_m[d] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("init_vld", 32'(v0), 32'd0);
        check("init_mask", 32'(m1), 32'd0);
        check("init_err", 32'(e2), 32'd0);
        check("init_rdy", 32'(r0), 32'd1);
        arst_n = 1'b1;

        req(LOAD, 2, 5); check("incl_2_5", 32'(m0), 32'h3C); check("excl_2_5", 32'(m1), 32'h1C);
        req(LOAD, 3, 3); check("incl_3_3", 32'(m0), 32'h08); check("excl_3_3", 32'(m1), 32'h00);
        req(LOAD, 6, 1); check("wrap_6_1", 32'(m0), 32'hC3);
        req(LOAD, 7, 0); check("wrap_7_0", 32'(m0), 32'h81);
        req(LOAD, 0, 1); check("acc_load", 32'(m0), 32'h03);
        req(SET, 4, 5);  check("acc_set", 32'(m0), 32'h33);
        req(CLR, 1, 4);  check("acc_clr", 32'(m0), 32'h21); check("acc_o_21", 32'(a0), 32'h21);
        req(FLUSH, 0, 0); check("flush_ent", 32'(m0), 32'h21); check("flush_acc", 32'(a0), 32'h00);
        req(SET, 7, 7);  check("set_7_7", 32'(m0), 32'h80);
        req(SET, 6, 2);
        check("w6_err", 32'(e2), 32'd1); check("w6_mask", 32'(m2), 32'h00);
        check("w6_acc", 32'(a2), 32'h00); check("w8_noerr", 32'(e0), 32'd0);
        check("w8_set_6_2", 32'(m0), 32'hC7);

        // drain, then back-pressure with three requests
        cycle(1'b0, LOAD, 0, 0, 1'b1, a);
        cycle(1'b1, SET, 3, 3, 1'b0, a);
        cycle(1'b1, SET, 4, 4, 1'b0, a);
        check("bp_rdy_low", 32'(r0), 32'd0);
        cycle(1'b1, SET, 5, 5, 1'b0, a);
        check("bp_held", 32'(a), 32'd0); check("bp_head0", 32'(m0), 32'hCF);
        cycle(1'b1, SET, 5, 5, 1'b1, a);
        check("bp_head1", 32'(m0), 32'hDF); check("bp_rdy_back", 32'(r0), 32'd1);
        cycle(1'b1, SET, 5, 5, 1'b1, a);
        check("bp_head2", 32'(m0), 32'hFF);
        cycle(1'b0, LOAD, 0, 0, 1'b1, a);
        check("bp_empty", 32'(v0), 32'd0);

        // reset with two entries queued
        cycle(1'b1, LOAD, 1, 2, 1'b0, a);
        cycle(1'b1, SET, 5, 6, 1'b0, a);
        async_reset();

        pend = 1'b0;
        vld = 1'b0; op = LOAD; lo = 0; hi = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                async_reset();
                pend = 1'b0;
            end
            if (!pend) begin
                vld = ($urandom_range(0, 9) < 7);
                op  = 2'($urandom_range(0, 3));
                lo  = int'($urandom_range(0, 7));
                hi  = int'($urandom_range(0, 7));
            end
            cycle(vld, op, lo, hi, ($urandom_range(0, 9) < 6), a);
            pend = vld && !a;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mask_range_acc.md
# mask_range_acc

Streaming range-mask generator with an accumulating mask register and a buffered valid/ready output. Each accepted request names a `[lo, hi]` index range, with wrap-around when `lo > hi`. The block expands the range to a W-bit mask and applies it to an internal accumulator as load, set, or clear, or flushes the accumulator. It emits one result per request through a 2-entry output queue. It is the sequential, range-capable successor to the single-index mask encoders, and is used by allocators and valid-vector maintenance logic.

## Interface
- `W`, default 32: mask width, W ≥ 2; need not be a power of two. Index width `X_W = $clog2(W)`.
- `P_INCLUSIVE`, default 1: 1 means `hi` is included in the range; 0 means `hi` is excluded. `lo` is always included.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `arst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_vld_i` input, 1 bit: request valid.
- `in_rdy_o` output, 1 bit: request ready.
- `in_op_i` input, 2 bits: 00 LOAD, 01 SET, 10 CLR, 11 FLUSH.
- `in_lo_i` input, X_W bits: range start index.
- `in_hi_i` input, X_W bits: range end index.
- `out_vld_o` output, 1 bit: head of the output queue is valid.
- `out_rdy_i` input, 1 bit: consumer ready.
- `out_mask_o` output, W bits: head entry mask.
- `out_err_o` output, 1 bit: head entry had an out-of-range index.
- `acc_o` output, W bits: current accumulator value (registered).

## Operation
- Handshake: a transfer occurs when `vld && rdy`. Once `vld` is asserted, the request or response fields must be held stable until the transfer completes.
- Range mask R, for i in 0..W-1:
  - `lo ≤ hi`: bit i is set when `lo ≤ i ≤ hi` (inclusive) or `lo ≤ i < hi` (exclusive).
  - `lo > hi` (wrap): bit i is set when `i ≥ lo` or `i ≤ hi` (inclusive, `i < hi` exclusive).
  - Exclusive with `lo == hi`: R = 0.
  - Inclusive with `lo == hi`: one bit is set.
- Out-of-range indices: if `lo ≥ W` or `hi ≥ W` (only possible when W is not a power of two):
  - R is forced to 0.
  - The accumulator is unchanged, including for LOAD.
  - The entry is written with `err = 1` and `mask = acc`.
  - FLUSH ignores `lo`/`hi`, so its `err` is always 0.
- Op semantics on accept, where `acc'` is the next accumulator value and E is the queued entry:
  - LOAD: `acc' = R`; `E = R`.
  - SET: `acc' = acc | R`; `E = acc'`.
  - CLR: `acc' = acc & ~R`; `E = acc'`.
  - FLUSH: `E = acc` (old value); `acc' = 0`.
- Output queue: 2-entry FIFO in arrival order.
  - `in_rdy_o = (count != 2)`, decoded from registered count only. There is no combinational path from `out_rdy_i` to `in_rdy_o`.
  - `out_vld_o = (count != 0)`.
- Simultaneous push and pop:
  - count unchanged.
  - If count is 1, the new entry becomes head on the next cycle.
  - If count is 2, no push occurs, because `in_rdy_o` is 0.
- Back-to-back accepted requests see the accumulator as updated by the previous request (read-after-write forwarding through the register; no hazard).

## Timing
- Latency: a request accepted in cycle N has its entry visible at the head in cycle N+1 when the queue was empty. `acc_o` reflects the update in cycle N+1.
- Throughput: 1 request/cycle sustained while `out_rdy_i` is held high. count stays at 1 in steady state.
- With `out_rdy_i` low: two requests are accepted; `in_rdy_o` falls in the cycle after the second accept and rises in the cycle after the first pop.
- Reset values, applied asynchronously while `arst_n` is low:
  - `acc_o = 0`, count = 0, FIFO storage = 0.
  - `out_vld_o = 0`, `out_mask_o = 0`, `out_err_o = 0`.
  - `in_rdy_o = 1`.
- Reset mid-operation: queued entries and the accumulator are discarded. The first cycle after deassertion behaves as empty.
- Outputs `out_*` and `acc_o` are driven from flops. `in_rdy_o` is decoded from flops only.

## Test plan
All scenarios use W=8 unless noted.
- Range expansion: LOAD lo=2 hi=5 → `out_mask_o = 0x3C` when `P_INCLUSIVE = 1`, `0x1C` when `P_INCLUSIVE = 0`. LOAD lo=hi=3 → `0x08` inclusive, `0x00` exclusive.
- Wrap (inclusive): LOAD lo=6 hi=1 → `0xC3`. LOAD lo=7 hi=0 → `0x81`.
- Accumulate (inclusive): LOAD 0,1 → `0x03`; SET 4,5 → `0x33`; CLR 1,4 → `0x21`; `acc_o = 0x21` one cycle after the last accept.
- Flush: from `acc = 0x21`, FLUSH → entry `0x21` and `acc_o = 0x00` next cycle. Then SET 7,7 → `0x80`.
- Backpressure: hold `out_rdy_i = 0` and present 3 requests back-to-back. Two are accepted; `in_rdy_o = 0`; the third is held. Raise `out_rdy_i` → all three entries emerge in order, one per cycle, with no loss or duplication.
- Errors and reset: with W=6, SET lo=6 hi=2 → `out_err_o = 1`, `out_mask_o = acc`, acc unchanged. Assert `arst_n` low with 2 entries queued → `out_vld_o = 0`, `acc_o = 0`, `in_rdy_o = 1` immediately, without waiting for a clock edge.
